// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the sequential ALU and anything that talks to it:
//   - OP_* : 6-bit MIPS-style function codes understood by the ALU
//   - state_e : FSM state encodings ST_IDLE / ST_SHIFT / ST_DONE
//   - sh_kind_e : shift flavour handed from the ALU to its shifter
// -----------------------------------------------------------------------------
package alu_seq_pkg;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_SLL = 6'b000000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10
    } sh_kind_e;

endpackage

// File: rtl/alu_shifter.sv
// -----------------------------------------------------------------------------
// alu_shifter
// Shift engine used by alu_seq for SLL / SRL / SRA.
//
// Build option ALU_FAST_SHIFT_EN:
//   defined   : purely combinational barrel shifter; o_res is the shifted i_data.
//   undefined : iterative shifter. i_start loads value, kind and count; every
//               following cycle shifts one bit and decrements the count. o_res
//               is the value after the *next* step and o_last flags that the
//               next step is the final one, so the caller can register the
//               result on that edge.
//
// Ports:
//   i_clk, i_reset, i_start, o_last : iterative build only
//   i_kind  : shift flavour (sh_kind_e encoding)
//   i_data  : operand to shift
//   i_cnt   : effective shift count, already saturated to NB_DATA
//   o_res   : shifted value (see above)
// -----------------------------------------------------------------------------
module alu_shifter
    import alu_seq_pkg::*;
#(
    parameter  int NB_DATA  = 8,
    localparam int NB_SHCNT = $clog2(NB_DATA) + 1
)
(
`ifndef ALU_FAST_SHIFT_EN
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    output logic                o_last,
`endif
    input  logic [1:0]          i_kind,
    input  logic [NB_DATA-1:0]  i_data,
    input  logic [NB_SHCNT-1:0] i_cnt,
    output logic [NB_DATA-1:0]  o_res
);

`ifdef ALU_FAST_SHIFT_EN

    // Single-cycle barrel shift; shifting by NB_DATA yields 0 / all sign bits.
    always_comb begin
        o_res = i_data;
        case (i_kind)
            SH_SLL:  o_res = i_data << i_cnt;
            SH_SRL:  o_res = i_data >> i_cnt;
            SH_SRA:  o_res = $unsigned($signed(i_data) >>> i_cnt);
            default: o_res = i_data;
        endcase
    end

`else

    logic [NB_DATA-1:0]  val_q;
    logic [NB_DATA-1:0]  val_d;
    logic [NB_SHCNT-1:0] cnt_q;
    logic [NB_SHCNT-1:0] cnt_d;
    logic [1:0]          kind_q;
    logic [1:0]          kind_d;
    logic [NB_DATA-1:0]  step_s;

    // One-bit shift of the held value in the latched direction.
    always_comb begin
        step_s = val_q;
        case (kind_q)
            SH_SLL:  step_s = {val_q[NB_DATA-2:0], 1'b0};
            SH_SRL:  step_s = {1'b0, val_q[NB_DATA-1:1]};
            SH_SRA:  step_s = {val_q[NB_DATA-1], val_q[NB_DATA-1:1]};
            default: step_s = val_q;
        endcase
    end

    // Load on start, otherwise step while the counter is non-zero.
    always_comb begin
        val_d  = val_q;
        cnt_d  = cnt_q;
        kind_d = kind_q;
        if (i_start) begin
            val_d  = i_data;
            cnt_d  = i_cnt;
            kind_d = i_kind;
        end else if (cnt_q != {NB_SHCNT{1'b0}}) begin
            val_d = step_s;
            cnt_d = cnt_q - NB_SHCNT'(1);
        end else begin
            val_d  = val_q;
            cnt_d  = cnt_q;
            kind_d = kind_q;
        end
    end

    // Shifter state registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            val_q  <= {NB_DATA{1'b0}};
            cnt_q  <= {NB_SHCNT{1'b0}};
            kind_q <= 2'b00;
        end else begin
            val_q  <= val_d;
            cnt_q  <= cnt_d;
            kind_q <= kind_d;
        end
    end

    assign o_res  = step_s;
    assign o_last = (cnt_q == NB_SHCNT'(1));

`endif

endmodule

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
// Clocked ALU with valid/ready handshakes on both sides. Supports ADD, SUB,
// AND, OR, XOR, NOR, SRA, SRL and SLL; any other opcode is flagged illegal.
// Result and flags are registered and held while o_valid && !i_ready.
//
// Build option ALU_FAST_SHIFT_EN:
//   defined   : shifts finish in one cycle like every other op (ST_SHIFT unused).
//   undefined : shifts take one extra cycle per bit of effective shift count.
//
// Ports:
//   i_clk, i_reset        : clock, synchronous active-high reset
//   i_valid / o_ready     : request handshake; accept when both high
//   i_op                  : opcode (NB_OP bits)
//   i_data_a, i_data_b    : signed operands; B is an unsigned count for shifts
//   o_valid / i_ready     : result handshake
//   o_res                 : signed NB_DATA+1 bit result
//   o_zero, o_ovf, o_err  : result==0, ADD/SUB signed overflow, illegal opcode
// -----------------------------------------------------------------------------
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
)
(
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [NB_OP-1:0]   i_op,
    input  logic [NB_DATA-1:0] i_data_a,
    input  logic [NB_DATA-1:0] i_data_b,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [NB_DATA:0]   o_res,
    output logic               o_zero,
    output logic               o_ovf,
    output logic               o_err
);

    localparam int NB_SHCNT = $clog2(NB_DATA) + 1;

    localparam logic [NB_OP-1:0] C_ADD = NB_OP'(OP_ADD);
    localparam logic [NB_OP-1:0] C_SUB = NB_OP'(OP_SUB);
    localparam logic [NB_OP-1:0] C_AND = NB_OP'(OP_AND);
    localparam logic [NB_OP-1:0] C_OR  = NB_OP'(OP_OR);
    localparam logic [NB_OP-1:0] C_XOR = NB_OP'(OP_XOR);
    localparam logic [NB_OP-1:0] C_NOR = NB_OP'(OP_NOR);
    localparam logic [NB_OP-1:0] C_SRA = NB_OP'(OP_SRA);
    localparam logic [NB_OP-1:0] C_SRL = NB_OP'(OP_SRL);
    localparam logic [NB_OP-1:0] C_SLL = NB_OP'(OP_SLL);

    // Sign-extend an NB_DATA-bit value into the result width.
    function automatic logic [NB_DATA:0] sext(input logic [NB_DATA-1:0] v);
        return {v[NB_DATA-1], v};
    endfunction

    state_e              state_q;
    state_e              state_d;
    logic                valid_q;
    logic                valid_d;
    logic [NB_DATA:0]    res_q;
    logic [NB_DATA:0]    res_d;
    logic                zero_q;
    logic                zero_d;
    logic                ovf_q;
    logic                ovf_d;
    logic                err_q;
    logic                err_d;

    logic                accept_s;
    logic                start_s;
    logic [NB_SHCNT-1:0] cnt_s;
    logic [1:0]          kind_s;
    logic [NB_DATA-1:0]  sh_res_s;
    logic [NB_DATA:0]    sa_s;
    logic [NB_DATA:0]    sb_s;
    logic [NB_DATA:0]    new_res_s;
    logic                new_ovf_s;
    logic                new_err_s;

    // A finished result can retire and a new request enter on the same edge.
    assign o_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && i_ready);
    assign accept_s = i_valid && o_ready;

    // Effective shift count: unsigned B saturated at NB_DATA.
    always_comb begin
        if (i_data_b >= NB_DATA'(NB_DATA)) begin
            cnt_s = NB_SHCNT'(NB_DATA);
        end else begin
            cnt_s = NB_SHCNT'(i_data_b);
        end
    end

    // Map the shift opcodes onto the shifter's direction encoding.
    always_comb begin
        kind_s = SH_SLL;
        case (i_op)
            C_SLL:   kind_s = SH_SLL;
            C_SRL:   kind_s = SH_SRL;
            C_SRA:   kind_s = SH_SRA;
            default: kind_s = SH_SLL;
        endcase
    end

`ifdef ALU_FAST_SHIFT_EN
    assign start_s = 1'b0;

    alu_shifter #(.NB_DATA(NB_DATA)) u_shifter (
        .i_kind (kind_s),
        .i_data (i_data_a),
        .i_cnt  (cnt_s),
        .o_res  (sh_res_s)
    );
`else
    logic is_shift_s;
    logic sh_last_s;

    assign is_shift_s = (i_op == C_SLL) || (i_op == C_SRL) || (i_op == C_SRA);
    // A zero-count shift completes immediately and never enters ST_SHIFT.
    assign start_s    = accept_s && is_shift_s && (cnt_s != {NB_SHCNT{1'b0}});

    alu_shifter #(.NB_DATA(NB_DATA)) u_shifter (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_start (start_s),
        .o_last  (sh_last_s),
        .i_kind  (kind_s),
        .i_data  (i_data_a),
        .i_cnt   (cnt_s),
        .o_res   (sh_res_s)
    );
`endif

    // Single-cycle result of the incoming request. ADD/SUB run one bit wider
    // on sign-extended operands so the result is exact.
    always_comb begin
        sa_s      = sext(i_data_a);
        sb_s      = sext(i_data_b);
        new_res_s = {(NB_DATA+1){1'b0}};
        new_ovf_s = 1'b0;
        new_err_s = 1'b0;
        case (i_op)
            C_ADD: begin
                new_res_s = sa_s + sb_s;
                new_ovf_s = new_res_s[NB_DATA] ^ new_res_s[NB_DATA-1];
            end
            C_SUB: begin
                new_res_s = sa_s - sb_s;
                new_ovf_s = new_res_s[NB_DATA] ^ new_res_s[NB_DATA-1];
            end
            C_AND:   new_res_s = sext(i_data_a & i_data_b);
            C_OR:    new_res_s = sext(i_data_a | i_data_b);
            C_XOR:   new_res_s = sext(i_data_a ^ i_data_b);
            C_NOR:   new_res_s = sext(~(i_data_a | i_data_b));
            C_SLL, C_SRL, C_SRA: begin
`ifdef ALU_FAST_SHIFT_EN
                new_res_s = sext(sh_res_s);
`else
                // Only used for a zero count; longer shifts finish in ST_SHIFT.
                new_res_s = sa_s;
`endif
            end
            default: begin
                new_res_s = {(NB_DATA+1){1'b0}};
                new_err_s = 1'b1;
            end
        endcase
    end

    // Control FSM: next state and next registered result/flags.
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    if (start_s) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_DONE;
                        res_d   = new_res_s;
                        zero_d  = (new_res_s == {(NB_DATA+1){1'b0}});
                        ovf_d   = new_ovf_s;
                        err_d   = new_err_s;
                    end
                end else if ((state_q == ST_DONE) && i_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            ST_SHIFT: begin
`ifdef ALU_FAST_SHIFT_EN
                state_d = ST_IDLE;
`else
                if (sh_last_s) begin
                    state_d = ST_DONE;
                    res_d   = sext(sh_res_s);
                    zero_d  = (sext(sh_res_s) == {(NB_DATA+1){1'b0}});
                    ovf_d   = 1'b0;
                    err_d   = 1'b0;
                end else begin
                    state_d = ST_SHIFT;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
        valid_d = (state_d == ST_DONE);
    end

    // State, result and flag registers; reset discards any in-flight op.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            res_q   <= {(NB_DATA+1){1'b0}};
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign o_valid = valid_q;
    assign o_res   = res_q;
    assign o_zero  = zero_q;
    assign o_ovf   = ovf_q;
    assign o_err   = err_q;

endmodule
